// File: rtl/sparse_pkg.sv
// Shared types and constants for the sparse serial event link (transmitter and receiver).
package sparse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic IDLE_LEVEL = 1'b0;

    // Address width for a mask of 'size' entries; never narrower than one bit.
    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/sparse_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag; purely combinational.
module sparse_prio_enc
    import sparse_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int ADDR_W = addr_width(SIZE)
) (
    input  logic [SIZE-1:0]   mask,
    output logic [ADDR_W-1:0] idx,
    output logic              any_set
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = ADDR_W'(i);
            end
        end
        any_set = |mask;
    end

endmodule

// File: rtl/sparse_event_rx.sv
// Deserializes one framed activity mask and emits the index of every set bit, lowest first,
// over a valid/ready handshake.
module sparse_event_rx
    import sparse_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          bitstream_in,
    output logic [addr_width(SIZE)-1:0]   addr_out,
    output logic                          addr_valid,
    input  logic                          addr_ready,
    output logic                          frame_done,
    output logic                          overrun
);

    localparam int ADDR_W = addr_width(SIZE);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    state_t            state_reg, state_next;
    logic [SIZE-1:0]   mask_reg, mask_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              frame_done_reg, frame_done_next;
    logic              overrun_reg, overrun_next;

    logic [ADDR_W-1:0] enc_idx;
    logic              enc_any;

    sparse_prio_enc #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_prio_enc (
        .mask    (mask_reg),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mask_reg       <= '0;
            count_reg      <= '0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (enable) begin
            state_reg      <= state_next;
            mask_reg       <= mask_next;
            count_reg      <= count_next;
            frame_done_reg <= frame_done_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        mask_next       = mask_reg;
        count_next      = count_reg;
        frame_done_next = 1'b0;
        overrun_next    = overrun_reg;
        case (state_reg)
            IDLE: begin
                if (bitstream_in == START_BIT) begin
                    count_next = '0;
                    mask_next  = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                mask_next[count_reg[ADDR_W-1:0]] = bitstream_in;
                count_next = count_reg + 1'b1;
                if (count_reg == LAST_BIT) begin
                    if (|mask_next) begin
                        state_next = EMIT;
                    end else begin
                        frame_done_next = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end
            EMIT: begin
                // A start bit here belongs to a frame we cannot buffer; flag it and drop it.
                if (bitstream_in != IDLE_LEVEL) begin
                    overrun_next = 1'b1;
                end
                if (addr_ready) begin
                    mask_next[enc_idx] = 1'b0;
                    if (mask_next == '0) begin
                        state_next      = IDLE;
                        frame_done_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign addr_valid = (state_reg == EMIT) && enc_any;
    assign addr_out   = addr_valid ? enc_idx : '0;
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;

endmodule
